cic_dec_ctrl: RTL and testbench
===============================

CIC_DEC_CTRL -- requirements
Module: cic_dec_ctrl

Interface
REQ-001 Parameter: DW, 16, width of the CIC datapath output word.
REQ-002 Parameter: N_STAGES, 3, number of CIC stages; sets the warm-up strobe count.
REQ-003 Parameter: FIFO_DEPTH, 4, number of output buffer entries, a power of 2.
REQ-004 Port: cic_clk, input, 1, single clock for the whole block.
REQ-005 Port: cic_rstn, input, 1, reset, asynchronous and active-low.
REQ-006 Port: cfg_start, input, 1, single-cycle pulse that starts decimation.
REQ-007 Port: cfg_stop, input, 1, single-cycle pulse that stops decimation.
REQ-008 Port: cfg_dec_r, input, 6, decimation ratio R; legal range 2..32.
REQ-009 Port: int_clr, output, 1, synchronous clear to the CIC integrator and comb registers.
REQ-010 Port: int_en, output, 1, enable for the integrators.
REQ-011 Port: comb_stb, output, 1, one-cycle decimation strobe to the comb section.
REQ-012 Port: samp_cnt, output, 5, decimation phase counter.
REQ-013 Port: dp_dout, input, DW, CIC datapath output.
REQ-014 Port: out_data, output, DW, head entry of the output FIFO.
REQ-015 Port: out_valid, output, 1, high when out_data holds a valid sample.
REQ-016 Port: out_ready, input, 1, downstream accept signal.
REQ-017 Port: busy, output, 1, high while the FSM is not IDLE or the FIFO is not empty.
REQ-018 Port: ovf, output, 1, sticky flag for a sample dropped by the FIFO.
REQ-019 Port: ovf_clr, input, 1, pulse that clears ovf.

Function
REQ-020 FSM SHALL have four states: IDLE, CLEAR, WARM and RUN.
REQ-021 IDLE to CLEAR on cfg_start; in the same cycle the block SHALL latch R_eff = clamp(cfg_dec_r, 2, 32).
REQ-022 Changes on cfg_dec_r SHALL be ignored outside the latch cycle; cfg_start SHALL be ignored when the FSM is not in IDLE.
REQ-023 CLEAR SHALL assert int_clr for exactly 2 cycles, hold int_en=0 and samp_cnt=0, then go to WARM.
REQ-024 In WARM and RUN, int_en=1 and samp_cnt SHALL count 0..R_eff-1 and wrap to 0.
REQ-025 comb_stb=1 exactly when int_en=1 and samp_cnt==R_eff-1, giving one pulse every R_eff cycles.
REQ-026 WARM SHALL discard the first N_STAGES strobes, then go to RUN on the cycle after the N_STAGES-th strobe.
REQ-027 In RUN, comb_stb at cycle t SHALL cause dp_dout to be sampled and pushed at t+1; out_valid rises at t+2 if the FIFO was empty.
REQ-028 cfg_stop in any non-IDLE state: FSM goes to IDLE next cycle, int_en=0, samp_cnt=0; any pending t+1 capture is cancelled.
REQ-029 cfg_start and cfg_stop in the same cycle: stop SHALL win.
REQ-030 On stop, FIFO contents SHALL be retained and remain drainable.
REQ-031 Pop SHALL occur when out_valid and out_ready are both high.
REQ-032 out_data and out_valid SHALL stay stable while out_valid=1 and out_ready=0.
REQ-033 Push while full with no pop: the new sample is dropped, the FIFO is unchanged and ovf is set.
REQ-034 Push and pop in the same cycle while full: the push is accepted and ovf is not set.
REQ-035 Push and pop in the same cycle while empty: the sample is stored and becomes visible the next cycle.
REQ-036 ovf_clr clears ovf, but a drop in the same cycle SHALL leave ovf=1.
REQ-037 busy = (state != IDLE) or (FIFO count != 0).

Reset
REQ-038 On cic_rstn=0, the block SHALL asynchronously enter IDLE and empty the FIFO.
REQ-039 During reset, int_clr, int_en, comb_stb, samp_cnt, out_valid, busy and ovf SHALL all be 0, and out_data=0.
REQ-040 Reset mid-operation SHALL discard all state; operation resumes only on a fresh cfg_start after release.

Verification
REQ-041 R=8, out_ready=1, start -> int_clr high for 2 cycles; comb_stb every 8 cycles; strobes 1-3 produce no output; strobe 4 at t gives out_valid at t+2 with out_data = dp_dout at t+1.
REQ-042 R=4, out_ready=0 -> 4 RUN pushes fill the FIFO; 5th strobe sets ovf; out_data still equals the first sample; ovf_clr then clears ovf.
REQ-043 cfg_dec_r=1 -> comb_stb period 2; cfg_dec_r=40 -> comb_stb period 32, samp_cnt wraps at 31.
REQ-044 Stop mid-RUN with 2 entries buffered -> int_en=0 next cycle; busy stays 1 until the 2nd pop, then 0.
REQ-045 cic_rstn pulsed low mid-RUN with FIFO non-empty -> all outputs 0 immediately, without a clock edge; no output until a new start.
REQ-046 cfg_start and cfg_stop together in IDLE -> FSM stays IDLE, int_clr never asserts.

Source files
------------

// File: rtl/cic_dec_ctrl.sv
// CIC decimator controller: sequences integrator clear/warm-up, generates the
// decimation strobe, captures the datapath output and buffers it in a small FIFO.
module cic_dec_ctrl #(
    parameter int DW         = 16,
    parameter int N_STAGES   = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          cic_clk,
    input  logic          cic_rstn,
    input  logic          cfg_start,
    input  logic          cfg_stop,
    input  logic [5:0]    cfg_dec_r,
    output logic          int_clr,
    output logic          int_en,
    output logic          comb_stb,
    output logic [4:0]    samp_cnt,
    input  logic [DW-1:0] dp_dout,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          ovf,
    input  logic          ovf_clr
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WW = (N_STAGES > 1) ? $clog2(N_STAGES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        WARM  = 2'd2,
        RUN   = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;

    // r_max holds the clamped ratio minus one, i.e. the last phase of a period
    logic [4:0]      r_max;
    logic            clr_cnt;
    logic [WW-1:0]   warm_cnt;
    logic            cap_pend;

    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;

    logic            start_ok;
    logic            stop_ok;
    logic            push;
    logic            pop;
    logic            full;
    logic            wr_en;
    logic            drop;

    // Clamp the requested ratio into 2..32 and return the last phase index.
    function automatic logic [4:0] clamp_max(input logic [5:0] r);
        logic [5:0] t;
        if (r < 6'd2) begin
            t = 6'd1;
        end else if (r > 6'd32) begin
            t = 6'd31;
        end else begin
            t = r - 6'd1;
        end
        return t[4:0];
    endfunction

    assign start_ok = (state == IDLE) && cfg_start && !cfg_stop;
    assign stop_ok  = (state != IDLE) && cfg_stop;

    assign int_clr  = (state == CLEAR);
    assign int_en   = (state == WARM) || (state == RUN);
    assign comb_stb = int_en && (samp_cnt == r_max);

    // FSM state register.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stop overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (stop_ok) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state_nxt = CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_cnt) begin
                        state_nxt = WARM;
                    end
                end
                WARM: begin
                    if (comb_stb && (warm_cnt == WW'(N_STAGES - 1))) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    state_nxt = RUN;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Latch the clamped decimation ratio only on an accepted start.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            r_max <= 5'd1;
        end else if (start_ok) begin
            r_max <= clamp_max(cfg_dec_r);
        end
    end

    // Decimation phase counter, free-running only while integrators are enabled.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            samp_cnt <= 5'd0;
        end else if (stop_ok || !int_en || comb_stb) begin
            samp_cnt <= 5'd0;
        end else begin
            samp_cnt <= samp_cnt + 5'd1;
        end
    end

    // Two-cycle timer for the integrator clear phase.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            clr_cnt <= 1'b0;
        end else if ((state == CLEAR) && !cfg_stop) begin
            clr_cnt <= ~clr_cnt;
        end else begin
            clr_cnt <= 1'b0;
        end
    end

    // Count strobes discarded while the comb pipeline fills.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            warm_cnt <= '0;
        end else if (state != WARM) begin
            warm_cnt <= '0;
        end else if (comb_stb && !cfg_stop) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    // Schedule a capture one cycle after each RUN strobe; stop cancels it.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            cap_pend <= 1'b0;
        end else begin
            cap_pend <= (state == RUN) && comb_stb && !cfg_stop;
        end
    end

    assign push  = cap_pend;
    assign pop   = out_valid && out_ready;
    assign full  = (count == (AW + 1)'(FIFO_DEPTH));
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // FIFO storage; contents are qualified by count so no reset is needed.
    always_ff @(posedge cic_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= dp_dout;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow flag; a drop wins over a simultaneous clear.
    always_ff @(posedge cic_clk or negedge cic_rstn) begin
        if (!cic_rstn) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovf_clr) begin
            ovf <= 1'b0;
        end
    end

    assign out_valid = (count != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign busy      = (state != IDLE) || (count != '0);

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// Directed bench for cic_dec_ctrl with a scoreboard of captured samples.
module tb_cic_dec_ctrl;

    localparam int DW = 16;

    logic          cic_clk = 1'b0;
    logic          cic_rstn;
    logic          cfg_start;
    logic          cfg_stop;
    logic [5:0]    cfg_dec_r;
    logic          int_clr;
    logic          int_en;
    logic          comb_stb;
    logic [4:0]    samp_cnt;
    logic [DW-1:0] dp_dout;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          ovf;
    logic          ovf_clr;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int s;
    int d;

    logic [DW-1:0] exp_q[$];
    int            cap_q[$];

    cic_dec_ctrl #(.DW(DW), .N_STAGES(3), .FIFO_DEPTH(4)) dut (
        .cic_clk   (cic_clk),
        .cic_rstn  (cic_rstn),
        .cfg_start (cfg_start),
        .cfg_stop  (cfg_stop),
        .cfg_dec_r (cfg_dec_r),
        .int_clr   (int_clr),
        .int_en    (int_en),
        .comb_stb  (comb_stb),
        .samp_cnt  (samp_cnt),
        .dp_dout   (dp_dout),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 cic_clk = ~cic_clk;

    // Unique datapath value for every cycle so captures can be identified.
    function automatic logic [DW-1:0] pattern(input int c);
        logic [31:0] v;
        v = 32'h5A00 + 32'(c) * 32'd37;
        return v[DW-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle: scoreboard pops/captures mid-cycle, then new dp_dout.
    task automatic applyStimulus();
        logic [DW-1:0] e;
        @(negedge cic_clk);
        if (out_valid && out_ready) begin
            vectors++;
            assert (exp_q.size() != 0) else begin
                miscompares++;
                $error("[TB] FAIL pop_empty: observed pop of %0h, expected no pop", out_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("pop_data", 32'(out_data), 32'(e));
            end
        end
        if (cap_q.size() != 0 && cap_q[0] == cyc) begin
            void'(cap_q.pop_front());
            exp_q.push_back(dp_dout);
        end
        @(posedge cic_clk);
        #1;
        cyc++;
        dp_dout = pattern(cyc);
    endtask

    task automatic run_to(input int target);
        while (cyc < target) applyStimulus();
    endtask

    initial begin
        cic_rstn  = 1'b0;
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        cfg_dec_r = 6'd8;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        dp_dout   = pattern(0);
        #3;
        $display("[TB] reset state");
        checkOutput("rst_int_clr",  32'(int_clr),   0);
        checkOutput("rst_int_en",   32'(int_en),    0);
        checkOutput("rst_comb_stb", 32'(comb_stb),  0);
        checkOutput("rst_samp_cnt", 32'(samp_cnt),  0);
        checkOutput("rst_valid",    32'(out_valid), 0);
        checkOutput("rst_busy",     32'(busy),      0);
        checkOutput("rst_ovf",      32'(ovf),       0);
        checkOutput("rst_data",     32'(out_data),  0);
        applyStimulus();
        cic_rstn = 1'b1;
        applyStimulus();

        // R=8, free-flowing output
        $display("[TB] R=8 warm-up and first samples");
        cfg_dec_r = 6'd8;
        out_ready = 1'b1;
        cfg_start = 1'b1;
        s = cyc;
        cap_q.push_back(s + 35);
        cap_q.push_back(s + 43);
        applyStimulus();
        cfg_start = 1'b0;
        cfg_dec_r = 6'd5;
        while (cyc <= s + 44) begin
            if (cyc <= s + 3) checkOutput("r8_int_clr", 32'(int_clr), 32'(cyc <= s + 2));
            if (cyc == s + 2) checkOutput("r8_int_en_clr", 32'(int_en), 0);
            if (cyc == s + 3) checkOutput("r8_int_en_warm", 32'(int_en), 1);
            if (cyc == s + 10) checkOutput("r8_samp_last", 32'(samp_cnt), 7);
            if (cyc == s + 36) checkOutput("r8_data", 32'(out_data), 32'(pattern(s + 35)));
            checkOutput("r8_comb_stb", 32'(comb_stb),
                        32'((cyc >= s + 10) && (((cyc - s - 10) % 8) == 0)));
            checkOutput("r8_valid", 32'(out_valid),
                        32'((cyc >= s + 36) && (((cyc - s - 36) % 8) == 0)));
            applyStimulus();
        end
        cfg_stop = 1'b1;
        applyStimulus();
        cfg_stop = 1'b0;
        checkOutput("r8_stop_int_en", 32'(int_en), 0);
        checkOutput("r8_stop_samp",   32'(samp_cnt), 0);
        applyStimulus();
        checkOutput("r8_idle_busy", 32'(busy), 0);

        // R=4, stalled output: fill, overflow, full push+pop, drain
        $display("[TB] R=4 overflow and drain");
        cfg_dec_r = 6'd4;
        out_ready = 1'b0;
        cfg_start = 1'b1;
        s = cyc;
        cap_q.push_back(s + 19);
        cap_q.push_back(s + 23);
        cap_q.push_back(s + 27);
        cap_q.push_back(s + 31);
        cap_q.push_back(s + 39);
        applyStimulus();
        cfg_start = 1'b0;
        run_to(s + 35);
        checkOutput("r4_full_valid", 32'(out_valid), 1);
        checkOutput("r4_ovf_pre",    32'(ovf), 0);
        checkOutput("r4_head_pre",   32'(out_data), 32'(pattern(s + 19)));
        ovf_clr = 1'b1;
        applyStimulus();
        ovf_clr = 1'b0;
        checkOutput("r4_ovf_set",  32'(ovf), 1);
        checkOutput("r4_head_ovf", 32'(out_data), 32'(pattern(s + 19)));
        ovf_clr = 1'b1;
        applyStimulus();
        ovf_clr = 1'b0;
        checkOutput("r4_ovf_clr", 32'(ovf), 0);
        run_to(s + 39);
        out_ready = 1'b1;
        applyStimulus();
        out_ready = 1'b0;
        checkOutput("r4_full_pushpop_ovf", 32'(ovf), 0);
        checkOutput("r4_head_after_pop",   32'(out_data), 32'(pattern(s + 23)));
        cfg_stop = 1'b1;
        applyStimulus();
        cfg_stop = 1'b0;
        checkOutput("r4_stop_int_en", 32'(int_en), 0);
        checkOutput("r4_stop_busy",   32'(busy), 1);
        out_ready = 1'b1;
        d = cyc;
        while (cyc < d + 4) begin
            checkOutput("r4_drain_busy", 32'(busy), 1);
            applyStimulus();
        end
        checkOutput("r4_drained_busy",  32'(busy), 0);
        checkOutput("r4_drained_valid", 32'(out_valid), 0);

        // Ratio clamping at both ends
        $display("[TB] ratio clamping");
        cfg_dec_r = 6'd1;
        cfg_start = 1'b1;
        s = cyc;
        applyStimulus();
        cfg_start = 1'b0;
        run_to(s + 4);
        checkOutput("r1_stb_a", 32'(comb_stb), 1);
        applyStimulus();
        checkOutput("r1_stb_gap", 32'(comb_stb), 0);
        checkOutput("r1_samp",    32'(samp_cnt), 0);
        applyStimulus();
        checkOutput("r1_stb_b", 32'(comb_stb), 1);
        applyStimulus();
        cfg_stop = 1'b1;
        applyStimulus();
        cfg_stop = 1'b0;
        checkOutput("r1_stop_int_en", 32'(int_en), 0);
        applyStimulus();
        cfg_dec_r = 6'd40;
        cfg_start = 1'b1;
        s = cyc;
        applyStimulus();
        cfg_start = 1'b0;
        run_to(s + 33);
        checkOutput("r40_stb_pre",  32'(comb_stb), 0);
        checkOutput("r40_samp_pre", 32'(samp_cnt), 30);
        applyStimulus();
        checkOutput("r40_stb",  32'(comb_stb), 1);
        checkOutput("r40_samp", 32'(samp_cnt), 31);
        applyStimulus();
        checkOutput("r40_wrap",     32'(samp_cnt), 0);
        checkOutput("r40_stb_post", 32'(comb_stb), 0);
        run_to(s + 66);
        checkOutput("r40_stb_2", 32'(comb_stb), 1);
        cfg_stop = 1'b1;
        applyStimulus();
        cfg_stop = 1'b0;
        applyStimulus();

        // Asynchronous reset mid-RUN with buffered samples
        $display("[TB] async reset mid-run");
        cfg_dec_r = 6'd2;
        out_ready = 1'b0;
        cfg_start = 1'b1;
        s = cyc;
        cap_q.push_back(s + 11);
        cap_q.push_back(s + 13);
        applyStimulus();
        cfg_start = 1'b0;
        run_to(s + 14);
        checkOutput("ar_valid_pre", 32'(out_valid), 1);
        checkOutput("ar_data_pre",  32'(out_data), 32'(pattern(s + 11)));
        checkOutput("ar_busy_pre",  32'(busy), 1);
        #1;
        cic_rstn = 1'b0;
        #1;
        checkOutput("ar_int_en",   32'(int_en), 0);
        checkOutput("ar_comb_stb", 32'(comb_stb), 0);
        checkOutput("ar_samp",     32'(samp_cnt), 0);
        checkOutput("ar_valid",    32'(out_valid), 0);
        checkOutput("ar_data",     32'(out_data), 0);
        checkOutput("ar_busy",     32'(busy), 0);
        exp_q.delete();
        cap_q.delete();
        #1;
        cic_rstn  = 1'b1;
        out_ready = 1'b1;
        d = cyc;
        while (cyc < d + 12) begin
            applyStimulus();
            checkOutput("ar_post_int_en", 32'(int_en), 0);
            checkOutput("ar_post_valid",  32'(out_valid), 0);
        end

        // Simultaneous start and stop in IDLE
        $display("[TB] start+stop together");
        cfg_dec_r = 6'd4;
        cfg_start = 1'b1;
        cfg_stop  = 1'b1;
        applyStimulus();
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        repeat (4) begin
            checkOutput("ss_int_clr", 32'(int_clr), 0);
            checkOutput("ss_busy",    32'(busy), 0);
            applyStimulus();
        end

        checkOutput("sb_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
